hex_display_mux: RTL and testbench

Time-multiplexed N-digit hexadecimal driver for common-anode seven-segment displays. It takes a packed hex value with per-digit decimal-point and blank masks. It scans one digit per refresh slot and drives shared active-low segment lines plus active-low digit enables. It sits between datapath status registers and the board display pins, replacing per-digit combinational decoders.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/display_refresh_timer.sv | 54 +++++
 rtl/hex_display_mux.sv | 167 ++++++++++++++++
 tb/tb_hex_display_mux.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg7_pkg
// Brief    : Shared seven-segment definitions: the active-low glyph table for
//            hex digits 0-F and the all-dark segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment
    localparam seg_t SEG_OFF = 7'b1111111;

    // Entry n is the glyph for nibble n (leftmost entry is F)
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic seg_t glyph(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : display_refresh_timer
// Brief    : Slot prescaler plus digit-index counter for a multiplexed
//            display. tc marks the last cycle of a slot; frame_wrap marks that
//            the scan sits in the final digit slot (tc & frame_wrap = wrap).
// Revision : 1.0 - initial release
// ============================================================================
module display_refresh_timer #(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [$clog2(REFRESH_DIV)-1:0] count,
    output logic [$clog2(NUM_DIGITS)-1:0]  index,
    output logic                          tc,
    output logic                          frame_wrap
);
    import seg7_pkg::*;

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_index;
    logic             w_tc;

    assign w_tc = (r_count == c_CNT_LAST);

    // Prescaler wraps every REFRESH_DIV cycles; index steps on each wrap and
    // is compared explicitly so non-power-of-2 digit counts never overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_index <= '0;
        end else if (w_tc) begin
            r_count <= '0;
            r_index <= (r_index == c_IDX_LAST) ? '0 : r_index + 1'b1;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count      = r_count;
    assign index      = r_index;
    assign tc         = w_tc;
    assign frame_wrap = (r_index == c_IDX_LAST);

endmodule
`default_nettype wire

// File: rtl/hex_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_mux
// Brief    : Time-multiplexed N-digit hex driver for common-anode seven-segment
//            displays with per-digit decimal point, blanking and optional
//            leading-zero suppression. Inputs are snapshotted once per frame.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
    output logic [6:0]              abcdefg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);
    import seg7_pkg::*;

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]        w_count;
    logic [IDX_W-1:0]        w_index;
    logic                    w_tc;
    logic                    w_last_slot;
    logic                    w_snap_load;
    logic                    w_guard;

    logic [4*NUM_DIGITS-1:0] r_snap_value;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [NUM_DIGITS-1:0]   r_snap_blank;
    logic                    r_snap_lz;

    logic                    w_zero_above;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic [3:0]              w_nibble;
    logic                    w_sel_dp;
    logic                    w_sel_blank;
    logic                    w_sel_supp;
    logic [6:0]              w_seg_next;
    logic                    w_dpn_next;
    logic [NUM_DIGITS-1:0]   w_an_next;

    logic [6:0]              r_abcdefg;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_start;

    display_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count      (w_count),
        .index      (w_index),
        .tc         (w_tc),
        .frame_wrap (w_last_slot)
    );

    // A new frame begins when the last slot of the last digit expires
    assign w_snap_load = w_tc & w_last_slot;

    // Anti-ghosting window at the head of each slot keeps all anodes off
    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_guard = 1'b0;
        end else begin : g_guard
            assign w_guard = (w_count < CNT_W'(GUARD));
        end
    endgenerate

    // Capture inputs once per frame; reset loads an all-blank snapshot so the
    // first frame is dark
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_value <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '1;
            r_snap_lz    <= 1'b0;
        end else if (w_snap_load) begin
            r_snap_value <= value;
            r_snap_dp    <= dp;
            r_snap_blank <= blank;
            r_snap_lz    <= lz_suppress;
        end
    end

    // Digit k is a leading zero when it and every higher nibble are zero;
    // digit 0 is never suppressed so a zero value still shows "0"
    always_comb begin
        w_zero_above = 1'b1;
        w_supp       = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above & (r_snap_value[4*k +: 4] == 4'h0);
            w_supp[k]    = r_snap_lz & w_zero_above;
        end
    end

    // Pick the snapshot fields of the digit currently being scanned
    always_comb begin
        w_nibble    = 4'h0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_supp  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_index == IDX_W'(i)) begin
                w_nibble    = r_snap_value[4*i +: 4];
                w_sel_dp    = r_snap_dp[i];
                w_sel_blank = r_snap_blank[i];
                w_sel_supp  = w_supp[i];
            end
        end
    end

    // Segment priority: forced blank, then leading-zero dark, then glyph
    always_comb begin
        w_seg_next = glyph(w_nibble);
        w_dpn_next = ~w_sel_dp;
        if (w_sel_blank) begin
            w_seg_next = SEG_OFF;
            w_dpn_next = 1'b1;
        end else if (w_sel_supp) begin
            w_seg_next = SEG_OFF;
        end
    end

    // One anode low for the scanned digit, none during the guard window
    always_comb begin
        w_an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!w_guard && (w_index == IDX_W'(i))) begin
                w_an_next[i] = 1'b0;
            end
        end
    end

    // Register all pin-facing outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_abcdefg     <= SEG_OFF;
            r_dp_n        <= 1'b1;
            r_an          <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_abcdefg     <= w_seg_next;
            r_dp_n        <= w_dpn_next;
            r_an          <= w_an_next;
            r_frame_start <= w_snap_load;
        end
    end

    assign abcdefg     = r_abcdefg;
    assign dp_n        = r_dp_n;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_mux
// Brief    : Directed self-checking bench for hex_display_mux with
//            NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1 (16-cycle frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_mux;

    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] G_0   = 7'b0000001;
    localparam logic [6:0] G_1   = 7'b1001111;
    localparam logic [6:0] G_2   = 7'b0010010;
    localparam logic [6:0] G_4   = 7'b1001100;
    localparam logic [6:0] G_A   = 7'b0001000;
    localparam logic [6:0] G_F   = 7'b0111000;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_suppress;
    logic [6:0]  abcdefg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_start;

    int total;
    int bad;

    hex_display_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .GUARD       (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .dp          (dp),
        .blank       (blank),
        .lz_suppress (lz_suppress),
        .abcdefg     (abcdefg),
        .dp_n        (dp_n),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame;
        for (int k = 0; k < 16; k++) tick;
    endtask

    task automatic test_reset;
        reset = 1'b1; value = 16'h12AF; dp = 4'b0000; blank = 4'b0000; lz_suppress = 1'b0;
        tick;
        tick;
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL reset_an: got %b want 1111", an); end
        total++; if (abcdefg !== S_OFF) begin bad++; $display("FAIL reset_seg: got %b want %b", abcdefg, S_OFF); end
        total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL reset_dpn: got %b want 1", dp_n); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick;
            total++; if (abcdefg !== S_OFF || dp_n !== 1'b1) begin bad++; $display("FAIL first_frame_dark cyc %0d: seg=%b dpn=%b want %b 1", k, abcdefg, dp_n, S_OFF); end
            total++; if (frame_start !== 1'(k == 16)) begin bad++; $display("FAIL first_frame_fs cyc %0d: got %b want %b", k, frame_start, k == 16); end
        end
    endtask

    task automatic test_basic_scan;
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        exp_seg[0] = G_F; exp_seg[1] = G_A; exp_seg[2] = G_2; exp_seg[3] = G_1;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                exp_an = (c == 0) ? 4'b1111 : 4'(~(4'b0001 << s));
                total++; if (an !== exp_an) begin bad++; $display("FAIL basic_an d%0d c%0d: got %b want %b", s, c, an, exp_an); end
                total++; if (abcdefg !== exp_seg[s]) begin bad++; $display("FAIL basic_seg d%0d c%0d: got %b want %b", s, c, abcdefg, exp_seg[s]); end
                total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL basic_dpn d%0d c%0d: got %b want 1", s, c, dp_n); end
                total++; if (frame_start !== 1'(s == 3 && c == 3)) begin bad++; $display("FAIL basic_fs d%0d c%0d: got %b", s, c, frame_start); end
            end
        end
    endtask

    task automatic test_lz_suppress;
        logic [6:0] exp_seg [2][4];
        logic [3:0] exp_an;
        exp_seg[0][0] = G_0; exp_seg[0][1] = G_4;   exp_seg[0][2] = S_OFF; exp_seg[0][3] = S_OFF;
        exp_seg[1][0] = G_0; exp_seg[1][1] = S_OFF; exp_seg[1][2] = S_OFF; exp_seg[1][3] = S_OFF;
        value = 16'h0040; lz_suppress = 1'b1;
        wait_frame;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) value = 16'h0000;
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    tick;
                    exp_an = (c == 0) ? 4'b1111 : 4'(~(4'b0001 << s));
                    total++; if (an !== exp_an) begin bad++; $display("FAIL lz_an f%0d d%0d c%0d: got %b want %b", f, s, c, an, exp_an); end
                    total++; if (abcdefg !== exp_seg[f][s]) begin bad++; $display("FAIL lz_seg f%0d d%0d c%0d: got %b want %b", f, s, c, abcdefg, exp_seg[f][s]); end
                    total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL lz_dpn f%0d d%0d c%0d: got %b want 1", f, s, c, dp_n); end
                end
            end
        end
    endtask

    task automatic test_dp_blank;
        logic [6:0] exp_seg [4];
        logic       exp_dpn [4];
        logic [3:0] exp_an;
        exp_seg[0] = G_F; exp_seg[1] = G_A;  exp_seg[2] = S_OFF; exp_seg[3] = G_1;
        exp_dpn[0] = 1'b0; exp_dpn[1] = 1'b1; exp_dpn[2] = 1'b1;  exp_dpn[3] = 1'b1;
        value = 16'h12AF; dp = 4'b0101; blank = 4'b0100; lz_suppress = 1'b0;
        wait_frame;
        dp = 4'b0000; blank = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                exp_an = (c == 0) ? 4'b1111 : 4'(~(4'b0001 << s));
                total++; if (an !== exp_an) begin bad++; $display("FAIL dpb_an d%0d c%0d: got %b want %b", s, c, an, exp_an); end
                total++; if (abcdefg !== exp_seg[s]) begin bad++; $display("FAIL dpb_seg d%0d c%0d: got %b want %b", s, c, abcdefg, exp_seg[s]); end
                total++; if (dp_n !== exp_dpn[s]) begin bad++; $display("FAIL dpb_dpn d%0d c%0d: got %b want %b", s, c, dp_n, exp_dpn[s]); end
            end
        end
    endtask

    task automatic test_no_tear;
        logic [6:0] exp_seg;
        value = 16'h1111;
        wait_frame;
        for (int f = 0; f < 2; f++) begin
            exp_seg = (f == 0) ? G_1 : G_2;
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    tick;
                    if (f == 0 && s == 2 && c == 0) value = 16'h2222;
                    total++; if (abcdefg !== exp_seg) begin bad++; $display("FAIL tear_seg f%0d d%0d c%0d: got %b want %b", f, s, c, abcdefg, exp_seg); end
                    total++; if (frame_start !== 1'(s == 3 && c == 3)) begin bad++; $display("FAIL tear_fs f%0d d%0d c%0d: got %b", f, s, c, frame_start); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        logic [3:0] exp_an;
        // From a frame boundary, 14 cycles leaves the scan at digit 3, prescaler 2
        for (int k = 0; k < 14; k++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL midrst_an: got %b want 1111", an); end
        total++; if (abcdefg !== S_OFF) begin bad++; $display("FAIL midrst_seg: got %b want %b", abcdefg, S_OFF); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL midrst_fs: got %b want 0", frame_start); end
        for (int k = 1; k <= 16; k++) begin
            tick;
            exp_an = ((k - 1) % 4 == 0) ? 4'b1111 : 4'(~(4'b0001 << ((k - 1) / 4)));
            total++; if (an !== exp_an) begin bad++; $display("FAIL midrst_scan_an cyc %0d: got %b want %b", k, an, exp_an); end
            total++; if (abcdefg !== S_OFF || dp_n !== 1'b1) begin bad++; $display("FAIL midrst_dark cyc %0d: seg=%b dpn=%b", k, abcdefg, dp_n); end
            total++; if (frame_start !== 1'(k == 16)) begin bad++; $display("FAIL midrst_fs cyc %0d: got %b want %b", k, frame_start, k == 16); end
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                exp_an = (c == 0) ? 4'b1111 : 4'(~(4'b0001 << s));
                total++; if (an !== exp_an) begin bad++; $display("FAIL midrst_post_an d%0d c%0d: got %b want %b", s, c, an, exp_an); end
                total++; if (abcdefg !== G_2) begin bad++; $display("FAIL midrst_post_seg d%0d c%0d: got %b want %b", s, c, abcdefg, G_2); end
            end
        end
    endtask

    task automatic test_long_run;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            tick;
            if (frame_start === 1'b1) pulses++;
            total++; if (frame_start !== 1'(i % 16 == 15)) begin bad++; $display("FAIL long_fs cyc %0d: got %b want %b", i, frame_start, i % 16 == 15); end
            total++; if ($countones(~an) > 1) begin bad++; $display("FAIL long_onehot cyc %0d: an=%b want at most one low", i, an); end
        end
        total++; if (pulses != 4) begin bad++; $display("FAIL long_pulse_count: got %0d want 4", pulses); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        value = 16'h0000;
        dp = 4'b0000;
        blank = 4'b0000;
        lz_suppress = 1'b0;
        test_reset;
        test_basic_scan;
        test_lz_suppress;
        test_dp_blank;
        test_no_tear;
        test_reset_mid_scan;
        test_long_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
